conv_row_scheduler: RTL and testbench

Frame-level sequencer for the 2D-convolution datapath. It latches a per-frame configuration and holds it stable for the whole frame. For each output row it starts `active_row_register` once the Input Buffer is ready, waits for the row to complete, and advances the IB window. After the last row it drains the systolic array and reports frame completion. It sits between the top-level command/CSR logic and the `active_row_register` / input-buffer pair.

---
 rtl/conv_row_scheduler_pkg.sv | 15 +
 rtl/conv_row_scheduler.sv | 107 ++++++++++
 tb/tb_conv_row_scheduler.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/conv_row_scheduler_pkg.sv
// conv_row_scheduler_pkg: shared pointer width, array geometry and scheduler state encoding
package conv_row_scheduler_pkg;
  localparam int PTR_WIDTH = 8;
  localparam int MAX_K_R = 7;
  localparam int MATRIX_A_ROW = 4;
  localparam int MATRIX_B_COL = 4;
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WAIT_IB = 3'd1,
    S_START   = 3'd2,
    S_RUN     = 3'd3,
    S_DRAIN   = 3'd4,
    S_DONE    = 3'd5
  } sched_state_t;
endpackage

// File: rtl/conv_row_scheduler.sv
// conv_row_scheduler: per-frame row sequencer between command logic and the ARR/input-buffer pair
module conv_row_scheduler
  import conv_row_scheduler_pkg::*;
#(
  parameter int DRAIN_CYCLES  = MATRIX_A_ROW + MATRIX_B_COL,
  parameter int START_TIMEOUT = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_async_n_i,
  input  logic                 frame_start_i,
  input  logic                 abort_i,
  input  logic [PTR_WIDTH-1:0] cfg_img_w_i,
  input  logic [PTR_WIDTH-1:0] cfg_img_h_i,
  input  logic [3:0]           cfg_kernel_r_i,
  input  logic                 ib_ready_i,
  output logic                 ib_advance_o,
  output logic                 arr_start_o,
  input  logic                 arr_busy_i,
  input  logic                 arr_row_done_i,
  output logic [PTR_WIDTH-1:0] arr_cfg_img_w_o,
  output logic [3:0]           arr_cfg_kernel_r_o,
  output logic [PTR_WIDTH-1:0] row_idx_o,
  output logic                 busy_o,
  output logic                 frame_done_o,
  output logic                 err_o
);
  localparam int CNT_MAX = DRAIN_CYCLES > START_TIMEOUT ? DRAIN_CYCLES : START_TIMEOUT;
  localparam int CNT_W = $clog2(CNT_MAX + 1);
  sched_state_t state;
  logic [PTR_WIDTH-1:0] out_h, row_idx, cfg_w, k_ext;
  logic [3:0] cfg_k;
  logic [CNT_W-1:0] cnt;
  logic err_q, adv_q, illegal, last_row;
  assign k_ext = PTR_WIDTH'(cfg_kernel_r_i);
  assign illegal = (cfg_kernel_r_i == 4'd0) || (cfg_kernel_r_i > 4'(MAX_K_R)) ||
                   (cfg_img_w_i < k_ext) || (cfg_img_h_i < k_ext);
  assign last_row = row_idx == out_h - PTR_WIDTH'(1);
  // One counter serves both the START timeout and the DRAIN flush; the states never overlap.
  always_ff @(posedge clk_i or negedge rst_async_n_i) begin
    if (!rst_async_n_i) begin
      state   <= S_IDLE;
      out_h   <= '0;
      row_idx <= '0;
      cfg_w   <= '0;
      cfg_k   <= '0;
      cnt     <= '0;
      err_q   <= 1'b0;
      adv_q   <= 1'b0;
    end else begin
      err_q <= 1'b0;
      adv_q <= 1'b0;
      if (abort_i) begin
        state   <= S_IDLE;
        row_idx <= '0;
        cnt     <= '0;
      end else begin
        case (state)
          S_IDLE: if (frame_start_i) begin
            if (illegal) err_q <= 1'b1;
            else begin
              state   <= S_WAIT_IB;
              row_idx <= '0;
              cfg_w   <= cfg_img_w_i;
              cfg_k   <= cfg_kernel_r_i;
              out_h   <= cfg_img_h_i - k_ext + PTR_WIDTH'(1);
            end
          end
          S_WAIT_IB: if (ib_ready_i) begin
            state <= S_START;
            cnt   <= '0;
          end
          S_START: begin
            if (arr_busy_i) state <= S_RUN;
            else if (cnt == CNT_W'(START_TIMEOUT - 1)) begin
              state <= S_IDLE;
              err_q <= 1'b1;
            end else cnt <= cnt + CNT_W'(1);
          end
          S_RUN: if (arr_row_done_i) begin
            if (last_row) begin
              state <= S_DRAIN;
              cnt   <= '0;
            end else begin
              state   <= S_WAIT_IB;
              adv_q   <= 1'b1;
              row_idx <= row_idx + PTR_WIDTH'(1);
            end
          end
          S_DRAIN: begin
            if (cnt == CNT_W'(DRAIN_CYCLES - 1)) state <= S_DONE;
            else cnt <= cnt + CNT_W'(1);
          end
          S_DONE: state <= S_IDLE;
          default: state <= S_IDLE;
        endcase
      end
    end
  end
  assign ib_advance_o       = adv_q;
  assign arr_start_o        = state == S_START;
  assign arr_cfg_img_w_o    = cfg_w;
  assign arr_cfg_kernel_r_o = cfg_k;
  assign row_idx_o          = row_idx;
  assign busy_o             = state != S_IDLE;
  assign frame_done_o       = state == S_DONE;
  assign err_o              = err_q;
endmodule

// File: tb/tb_conv_row_scheduler.sv
// tb_conv_row_scheduler: table-driven, hand-sequenced and randomized frame checks against an event-level model
module tb_conv_row_scheduler;
  import conv_row_scheduler_pkg::*;
  localparam int D = MATRIX_A_ROW + MATRIX_B_COL;
  logic clk = 1'b0;
  logic rst_async_n_i = 1'b1;
  logic frame_start_i = 1'b0, abort_i = 1'b0, ib_ready_i = 1'b1;
  logic arr_busy_i = 1'b0, arr_row_done_i = 1'b0;
  logic [PTR_WIDTH-1:0] cfg_img_w_i = '0, cfg_img_h_i = '0;
  logic [3:0] cfg_kernel_r_i = '0;
  logic ib_advance_o, arr_start_o, busy_o, frame_done_o, err_o;
  logic [PTR_WIDTH-1:0] arr_cfg_img_w_o, row_idx_o;
  logic [3:0] arr_cfg_kernel_r_o;
  conv_row_scheduler dut (
    .clk_i(clk), .rst_async_n_i(rst_async_n_i), .frame_start_i(frame_start_i), .abort_i(abort_i),
    .cfg_img_w_i(cfg_img_w_i), .cfg_img_h_i(cfg_img_h_i), .cfg_kernel_r_i(cfg_kernel_r_i),
    .ib_ready_i(ib_ready_i), .ib_advance_o(ib_advance_o), .arr_start_o(arr_start_o),
    .arr_busy_i(arr_busy_i), .arr_row_done_i(arr_row_done_i), .arr_cfg_img_w_o(arr_cfg_img_w_o),
    .arr_cfg_kernel_r_o(arr_cfg_kernel_r_o), .row_idx_o(row_idx_o), .busy_o(busy_o),
    .frame_done_o(frame_done_o), .err_o(err_o)
  );
  always #5 clk = ~clk;
  typedef struct {
    int w, h, k, blen;
    int e_err, e_start, e_adv, e_done;
  } vec_t;
  vec_t tbl[8];
  int n_pass = 0, n_tot = 0;
  int cyc = 0, n_adv, n_done, n_err, n_start, n_busy, start_cyc, t_done, t_rd, max_row;
  int arr_cnt = 0, blen = 10;
  bit arr_en = 1'b1, rand_ib = 1'b0, prev_start = 1'b0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask
  task automatic clear();
    n_adv = 0; n_done = 0; n_err = 0; n_start = 0; n_busy = 0;
    start_cyc = 0; t_done = -1; t_rd = -1; max_row = 0;
  endtask
  // One clock: observe outputs, then let the ARR/IB models drive the next inputs.
  task automatic step();
    logic ib_prev;
    ib_prev = ib_ready_i;
    @(posedge clk); #1;
    cyc++;
    if (busy_o) n_busy++;
    if (arr_start_o) start_cyc++;
    if (arr_start_o && !prev_start) begin
      n_start++;
      chk("start_after_ib", ib_prev, 1);
    end
    prev_start = arr_start_o;
    if (ib_advance_o) begin
      n_adv++;
      chk("row_idx_step", row_idx_o, n_adv);
    end
    if (frame_done_o) begin n_done++; t_done = cyc; end
    if (err_o) n_err++;
    if (int'(row_idx_o) > max_row) max_row = int'(row_idx_o);
    arr_row_done_i = 1'b0;
    if (arr_cnt > 0) begin
      arr_cnt--;
      if (arr_cnt == 0) begin arr_busy_i = 1'b0; arr_row_done_i = 1'b1; t_rd = cyc; end
    end else if (arr_start_o && arr_en) begin
      arr_busy_i = 1'b1;
      arr_cnt = blen;
    end
    if (rand_ib) ib_ready_i = ($urandom_range(0, 3) != 0);
  endtask
  task automatic start_frame(input int w, input int h, input int k);
    cfg_img_w_i = PTR_WIDTH'(w);
    cfg_img_h_i = PTR_WIDTH'(h);
    cfg_kernel_r_i = 4'(k);
    frame_start_i = 1'b1;
    step();
    frame_start_i = 1'b0;
  endtask
  task automatic finish_frame(input string tag);
    for (int i = 0; i < 4000 && busy_o; i++) step();
    chk({tag, "_terminates"}, busy_o, 0);
  endtask
  task automatic run_vec(input string tag, input int w, input int h, input int k, input int bl,
                         input int e_err, input int e_start, input int e_adv, input int e_done);
    clear();
    blen = bl;
    start_frame(w, h, k);
    finish_frame(tag);
    chk({tag, "_err"}, n_err, e_err);
    chk({tag, "_starts"}, n_start, e_start);
    chk({tag, "_advances"}, n_adv, e_adv);
    chk({tag, "_done"}, n_done, e_done);
    if (e_done != 0) begin
      chk({tag, "_done_latency"}, t_done, t_rd + 1 + D);
      chk({tag, "_cfg_w"}, arr_cfg_img_w_o, w);
      chk({tag, "_cfg_k"}, arr_cfg_kernel_r_o, k);
      chk({tag, "_last_row"}, max_row, e_start - 1);
    end else chk({tag, "_busy_cycles"}, n_busy, 0);
    repeat (2) step();
  endtask
  initial begin
    bit ok;
    int w, h, k, oh;
    bit legal;
    tbl[0] = '{8, 6, 3, 10, 0, 4, 3, 1};
    tbl[1] = '{8, 6, 0, 3, 1, 0, 0, 0};
    tbl[2] = '{10, 10, 8, 3, 1, 0, 0, 0};
    tbl[3] = '{8, 2, 3, 3, 1, 0, 0, 0};
    tbl[4] = '{2, 9, 3, 3, 1, 0, 0, 0};
    tbl[5] = '{5, 3, 3, 4, 0, 1, 0, 1};
    tbl[6] = '{7, 9, 7, 2, 0, 3, 2, 1};
    tbl[7] = '{4, 5, 1, 1, 0, 5, 4, 1};
    rst_async_n_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy_o, 0);
    chk("rst_arr_start", arr_start_o, 0);
    chk("rst_row_idx", row_idx_o, 0);
    chk("rst_cfg_w", arr_cfg_img_w_o, 0);
    chk("rst_cfg_k", arr_cfg_kernel_r_o, 0);
    chk("rst_flags", {ib_advance_o, frame_done_o, err_o}, 0);
    #3 rst_async_n_i = 1'b1;
    step();
    for (int i = 0; i < 8; i++)
      run_vec($sformatf("vec%0d", i), tbl[i].w, tbl[i].h, tbl[i].k, tbl[i].blen,
              tbl[i].e_err, tbl[i].e_start, tbl[i].e_adv, tbl[i].e_done);
    // IB not ready for 7 cycles after the first row completes
    clear();
    blen = 10;
    start_frame(8, 6, 3);
    for (int i = 0; i < 200 && !arr_row_done_i; i++) step();
    ib_ready_i = 1'b0;
    ok = 1'b1;
    repeat (7) begin step(); if (arr_start_o) ok = 1'b0; end
    chk("ib_gap_start_held", ok, 1);
    ib_ready_i = 1'b1;
    step();
    chk("ib_gap_start_next", arr_start_o, 1);
    finish_frame("ib_gap");
    chk("ib_gap_starts", n_start, 4);
    chk("ib_gap_advances", n_adv, 3);
    chk("ib_gap_done", n_done, 1);
    // ARR never answers: START times out
    clear();
    arr_en = 1'b0;
    start_frame(8, 6, 3);
    finish_frame("timeout");
    arr_en = 1'b1;
    chk("timeout_err", n_err, 1);
    chk("timeout_start_cycles", start_cyc, 16);
    chk("timeout_done", n_done, 0);
    // abort collides with the row-2 completion
    clear();
    start_frame(8, 6, 3);
    for (int i = 0; i < 500 && !(arr_row_done_i && row_idx_o == 2); i++) step();
    chk("abort_reached_row2", arr_row_done_i && row_idx_o == 2, 1);
    abort_i = 1'b1;
    step();
    abort_i = 1'b0;
    chk("abort_busy", busy_o, 0);
    chk("abort_row_idx", row_idx_o, 0);
    chk("abort_flags", {ib_advance_o, frame_done_o, err_o}, 0);
    repeat (20) step();
    chk("abort_advances", n_adv, 2);
    chk("abort_no_done", n_done, 0);
    chk("abort_cfg_kept", arr_cfg_img_w_o, 8);
    run_vec("after_abort", 8, 6, 3, 10, 0, 4, 3, 1);
    // asynchronous reset in the middle of DRAIN
    clear();
    start_frame(8, 6, 3);
    for (int i = 0; i < 500 && !(arr_row_done_i && row_idx_o == 3); i++) step();
    repeat (3) step();
    chk("drain_reached", {busy_o, arr_start_o}, 2'b10);
    #2 rst_async_n_i = 1'b0;
    #1;
    chk("async_rst_outputs", {busy_o, arr_start_o, ib_advance_o, frame_done_o, err_o,
                              row_idx_o, arr_cfg_img_w_o, arr_cfg_kernel_r_o}, 0);
    repeat (3) step();
    #3 rst_async_n_i = 1'b1;
    repeat (20) step();
    chk("async_rst_no_done", n_done, 0);
    chk("async_rst_idle", busy_o, 0);
    // randomized frames against the event-level model
    rand_ib = 1'b1;
    for (int n = 0; n < 14; n++) begin
      w = $urandom_range(0, 12);
      h = $urandom_range(0, 14);
      k = $urandom_range(0, 8);
      legal = k > 0 && k <= MAX_K_R && w >= k && h >= k;
      oh = h - k + 1;
      run_vec($sformatf("rand%0d_w%0d_h%0d_k%0d", n, w, h, k), w, h, k, $urandom_range(1, 4),
              legal ? 0 : 1, legal ? oh : 0, legal ? oh - 1 : 0, legal ? 1 : 0);
    end
    rand_ib = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
